// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: boot loader that parses a framed UART byte stream
// (SYNC, CNT, (CNT+1) big-endian 32-bit words, XOR checksum), writes the
// words to instruction memory from address 0 and holds the CPU until a
// frame with a valid checksum has been loaded.
module imem_boot_ctrl #(
    parameter int          ADDR_W  = 6,
    parameter int          TIMEOUT = 50000,
    parameter logic [7:0]  SYNC    = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              pc_load,
    output logic              busy,
    output logic              load_done,
    output logic              load_error
);

    // Idle counter must be able to hold TIMEOUT (it steps once past
    // TIMEOUT-1 on the abort edge before being cleared in IDLE).
    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_CHECK
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [TO_W-1:0]     r_idle;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   r_widx;
    logic [1:0]          r_bcnt;
    logic [23:0]         r_word;
    logic [7:0]          r_chk;

    logic                w_timeout;
    logic                w_cnt_bad;
    logic [15:0]         w_rx_ext;

    logic                w_start;
    logic                w_abort;
    logic                w_latch;
    logic                w_byte;
    logic                w_word_done;
    logic                w_good;

    assign w_rx_ext  = {8'd0, rx_data};

    // A CNT byte is too large when any bit at or above ADDR_W is set,
    // i.e. the frame would not fit into 2^ADDR_W words.
    assign w_cnt_bad = ((w_rx_ext >> ADDR_W) != 16'd0);

    // A byte arriving in the same cycle the counter expires wins over
    // the timeout, so a frame is never aborted while it is still moving.
    assign w_timeout = (r_state != S_IDLE) && !rx_valid &&
                       (r_idle == TO_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and one-cycle action strobes for the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_abort     = 1'b0;
        w_latch     = 1'b0;
        w_byte      = 1'b0;
        w_word_done = 1'b0;
        w_good      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx_valid && (rx_data == SYNC)) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_COUNT;
                end
            end
            S_COUNT: begin
                if (w_timeout) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (rx_valid) begin
                    if (w_cnt_bad) begin
                        w_abort     = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_timeout) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (rx_valid) begin
                    w_byte = 1'b1;
                    if (r_bcnt == 2'd3) begin
                        w_word_done = 1'b1;
                        if (r_widx == r_cnt) begin
                            w_state_nxt = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (w_timeout) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (rx_valid) begin
                    w_state_nxt = S_IDLE;
                    if (rx_data == r_chk) begin
                        w_good = 1'b1;
                    end else begin
                        w_abort = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status outputs: hold is set by SYNC and released only by a good
    // checksum; the error flag is sticky until the next SYNC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_hold   <= 1'b0;
            load_error <= 1'b0;
            load_done  <= 1'b0;
            pc_load    <= 1'b0;
            busy       <= 1'b0;
            imem_we    <= 1'b0;
        end else begin
            if (w_start) begin
                cpu_hold <= 1'b1;
            end else if (w_good) begin
                cpu_hold <= 1'b0;
            end
            if (w_start) begin
                load_error <= 1'b0;
            end else if (w_abort) begin
                load_error <= 1'b1;
            end
            load_done <= w_good;
            pc_load   <= w_good;
            busy      <= (r_state != S_IDLE);
            imem_we   <= w_word_done;
        end
    end

    // IMEM write port: address and data are held between writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else if (w_word_done) begin
            imem_addr  <= r_widx;
            imem_wdata <= {r_word, rx_data};
        end
    end

    // Inter-byte idle counter; parked at zero while no frame is open.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idle <= '0;
        end else if ((r_state == S_IDLE) || rx_valid) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + TO_W'(1);
        end
    end

    // Frame datapath: word count latch, byte assembly, word index, checksum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_widx <= '0;
            r_bcnt <= '0;
            r_word <= '0;
            r_chk  <= '0;
        end else begin
            if (w_start) begin
                r_widx <= '0;
                r_bcnt <= '0;
                r_word <= '0;
                r_chk  <= '0;
            end
            if (w_latch) begin
                r_cnt <= w_rx_ext[ADDR_W-1:0];
            end
            if (w_byte) begin
                r_word <= {r_word[15:0], rx_data};
                r_chk  <= r_chk ^ rx_data;
                r_bcnt <= r_bcnt + 2'd1;
                if (r_bcnt == 2'd3) begin
                    r_widx <= r_widx + ADDR_W'(1);
                end
            end
        end
    end

endmodule
